// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module  : data_mem_responder
// Brief   : Word-array responder for the MEM-stage load/store port. Handles one
//           access at a time with a fixed-latency response pulse and a stall.
// Rev     : 1.0  initial release
// ============================================================================
module data_mem_responder #(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic        i_req_write,
    input  logic [31:0] i_req_addr,
    input  logic [31:0] i_req_wdata,
    output logic        o_resp_valid,
    output logic [31:0] o_resp_rdata,
    output logic        o_resp_err,
    output logic        o_stall
);
    localparam int          c_IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0]  c_CNT_INIT = 4'(LATENCY - 1);
    localparam logic        c_PASS     = (LATENCY == 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [3:0]           r_count;
    logic [3:0]           w_count_nxt;
    logic                 w_ready;
    logic                 w_stall;
    logic                 w_resp_valid;
    logic                 w_accept;
    logic                 w_enter_resp;

    logic                 r_write;
    logic                 r_err;
    logic [c_IDX_W-1:0]   r_idx;
    logic [31:0]          r_wdata;
    logic [31:0]          r_rdata;
    logic                 r_resp_err;
    logic [31:0]          r_mem [DEPTH];

    logic                 w_addr_err;
    logic [c_IDX_W-1:0]   w_idx_in;
    logic                 w_acc_write;
    logic                 w_acc_err;
    logic [c_IDX_W-1:0]   w_acc_idx;
    logic [31:0]          w_acc_wdata;

    assign w_addr_err = (i_req_addr[1:0] != 2'b00) |
                        ({2'b00, i_req_addr[31:2]} >= 32'(DEPTH));
    assign w_idx_in   = i_req_addr[c_IDX_W+1:2];

    always_comb begin
        w_state_nxt  = r_state;
        w_count_nxt  = r_count;
        w_ready      = 1'b0;
        w_stall      = 1'b0;
        w_resp_valid = 1'b0;
        w_accept     = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_ready = rst_n;
            end
            S_WAIT: begin
                w_stall     = 1'b1;
                w_count_nxt = 4'(r_count - 4'd1);
                if (r_count == 4'd1) begin
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                w_ready      = rst_n;
                w_resp_valid = 1'b1;
                w_state_nxt  = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        w_accept = w_ready & i_req_valid;
        if (w_accept) begin
            w_stall     = 1'b1;
            w_count_nxt = c_CNT_INIT;
            w_state_nxt = c_PASS ? S_RESP : S_WAIT;
        end
    end

    // With single-cycle latency the access is performed on the acceptance
    // edge itself, so it must use the live request rather than the latch.
    assign w_enter_resp = rst_n & (w_state_nxt == S_RESP);
    assign w_acc_write  = c_PASS ? i_req_write : r_write;
    assign w_acc_err    = c_PASS ? w_addr_err  : r_err;
    assign w_acc_idx    = c_PASS ? w_idx_in    : r_idx;
    assign w_acc_wdata  = c_PASS ? i_req_wdata : r_wdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_count <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_write    <= 1'b0;
            r_err      <= 1'b0;
            r_idx      <= '0;
            r_wdata    <= 32'd0;
            r_rdata    <= 32'd0;
            r_resp_err <= 1'b0;
        end else begin
            if (w_accept) begin
                r_write <= i_req_write;
                r_err   <= w_addr_err;
                r_idx   <= w_idx_in;
                r_wdata <= i_req_wdata;
            end
            if (w_enter_resp) begin
                r_resp_err <= w_acc_err;
                r_rdata    <= (w_acc_err | w_acc_write) ? 32'd0 : r_mem[w_acc_idx];
            end
        end
    end

    // Array is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (w_enter_resp & w_acc_write & ~w_acc_err) begin
            r_mem[w_acc_idx] <= w_acc_wdata;
        end
    end

    assign o_req_ready  = w_ready;
    assign o_stall      = w_stall;
    assign o_resp_valid = w_resp_valid;
    assign o_resp_rdata = r_rdata;
    assign o_resp_err   = r_resp_err;

endmodule
`default_nettype wire
